// File: rtl/switch_conditioner.sv
// Purpose: synchronize, debounce and one-hot-qualify four raw board switches into press pulses.
// Latency: DEBOUNCE_CYCLES+1 edges from the first edge that samples a settled raw level to the stable/pulse update.
// Backpressure: none; the pulses are fire-and-forget and a rejected press raises a one-cycle conflict pulse.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset_n    asynchronous active-low reset, clears every flop
//   raw_sw     raw switch pins (bit 0 -> SW1 ... bit 3 -> SW4), asynchronous to clk
//   SW1..SW4   registered one-cycle press pulses, never more than one high at a time
//   stable_sw  debounced switch levels
//   conflict   registered one-cycle pulse when a press is rejected
module switch_conditioner #(
    parameter int  DEBOUNCE_CYCLES = 4,
    localparam int CNT_W           = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] raw_sw,
    output logic       SW1,
    output logic       SW2,
    output logic       SW3,
    output logic       SW4,
    output logic [3:0] stable_sw,
    output logic       conflict
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [3:0]       stable_q, stable_d;
    logic [3:0]       press_q, press_d;
    logic             conflict_q, conflict_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       rise;
    logic             single_rise;

    always_comb begin
        sync1_d    = raw_sw;
        sync2_d    = sync1_q;
        stable_d   = stable_q;
        press_d    = '0;
        conflict_d = 1'b0;

        // The counter only runs while the synchronized level disagrees with the
        // stable level; any agreement (a bounce back) restarts the window.
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end

        rise        = stable_d & ~stable_q;
        single_rise = (rise != 4'd0) && ((rise & (rise - 4'd1)) == 4'd0);

        // A press is only accepted when the new stable vector is exactly the
        // rising bit; simultaneous rises or a rise on top of a held switch
        // are reported as a conflict instead.
        if (single_rise && (stable_d == rise)) begin
            press_d = rise;
        end else if (rise != 4'd0) begin
            conflict_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            press_q    <= '0;
            conflict_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            press_q    <= press_d;
            conflict_q <= conflict_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign SW1       = press_q[0];
    assign SW2       = press_q[1];
    assign SW3       = press_q[2];
    assign SW4       = press_q[3];
    assign stable_sw = stable_q;
    assign conflict  = conflict_q;

endmodule
